// File: rtl/i2s_frame_capture_if.sv
// Sample output channel of the I2S frame capture block: valid/ready handshake
// carrying one captured left-channel word plus its end-of-frame marker.
`timescale 1ns/1ps
interface i2s_frame_capture_if #(
    parameter int SAMPLE_W = 24
);
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_valid;
    logic                sample_ready;
    logic                sample_last;

    modport master (
        output sample_data,
        output sample_valid,
        output sample_last,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        input  sample_last,
        output sample_ready
    );
endinterface

// File: rtl/i2s_frame_capture.sv
// Captures one frame of FRAME_LEN left-channel I2S words into a valid/ready stream.
// Optional feature macro: I2S_CAP_OVERRUN_CNT_EN enables the saturating dropped-sample counter.
`timescale 1ns/1ps
module i2s_frame_capture #(
    parameter int SAMPLE_W  = 24,
    parameter int FRAME_LEN = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bck,
    input  logic                  lrck,
    input  logic                  sd,
    input  logic                  start,
    input  logic                  abort,
    i2s_frame_capture_if.master   smp,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic [7:0]            overrun_cnt
);

    localparam int FC_W   = $clog2(FRAME_LEN);
    localparam int SLOT_W = 6;
    localparam logic [FC_W-1:0]   LAST_IDX  = FC_W'(FRAME_LEN - 1);
    localparam logic [SLOT_W-1:0] SLOT_FULL = SLOT_W'(SAMPLE_W);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          bck_sync_q, bck_sync_d;
    logic [2:0]          lrck_sync_q, lrck_sync_d;
    logic [2:0]          sd_sync_q, sd_sync_d;
    logic                fall_pend_q, fall_pend_d;
    logic                in_word_q, in_word_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [SAMPLE_W-1:0] sample_data_q, sample_data_d;
    logic                sample_valid_q, sample_valid_d;
    logic                sample_last_q, sample_last_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                overrun_q, overrun_d;

    logic bck_rise_s, lrck_fall_s, lrck_s, sd_s;
    logic word_start_s, word_done_s, handshake_s;
    logic ovr_inc_s, ovr_clr_s;
    logic sync_unused_s;

    // Synchronizer shift and edge/level decode
    always_comb begin
        bck_sync_d    = {bck_sync_q[1:0], bck};
        lrck_sync_d   = {lrck_sync_q[1:0], lrck};
        sd_sync_d     = {sd_sync_q[1:0], sd};
        bck_rise_s    = ~bck_sync_q[2] & bck_sync_q[1];
        lrck_fall_s   = lrck_sync_q[2] & ~lrck_sync_q[1];
        lrck_s        = lrck_sync_q[1];
        sd_s          = sd_sync_q[1];
        sync_unused_s = sd_sync_q[2];
        // lrck toggles on the falling bck edge, so the delay-slot rise may come later.
        word_start_s  = bck_rise_s & (lrck_fall_s | fall_pend_q);
        word_done_s   = in_word_q & (slot_q == SLOT_FULL);
        handshake_s   = sample_valid_q & smp.sample_ready;
        if (bck_rise_s) begin
            fall_pend_d = 1'b0;
        end else if (lrck_fall_s) begin
            fall_pend_d = 1'b1;
        end else begin
            fall_pend_d = fall_pend_q;
        end
    end

    // Capture FSM, bit engine, frame counting and output staging
    always_comb begin
        state_d        = state_q;
        in_word_d      = in_word_q;
        slot_d         = slot_q;
        shift_d        = shift_q;
        frame_cnt_d    = frame_cnt_q;
        sample_data_d  = sample_data_q;
        sample_valid_d = sample_valid_q;
        sample_last_d  = sample_last_q;
        frame_done_d   = 1'b0;
        overrun_d      = overrun_q;
        ovr_inc_s      = 1'b0;
        ovr_clr_s      = 1'b0;

        // The bit engine keeps running in HOLD so a second word can be detected as an overrun.
        if (state_q == CAPTURE || state_q == HOLD) begin
            if (word_start_s) begin
                slot_d    = {SLOT_W{1'b0}};
                in_word_d = 1'b1;
            end else if (in_word_q && bck_rise_s && !lrck_s && slot_q < SLOT_FULL) begin
                slot_d  = slot_q + 6'd1;
                shift_d = {shift_q[SAMPLE_W-2:0], sd_s};
            end else begin
                slot_d = slot_q;
            end
        end else begin
            in_word_d = in_word_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ARM;
                    overrun_d = 1'b0;
                    ovr_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                if (word_start_s) begin
                    slot_d    = {SLOT_W{1'b0}};
                    in_word_d = 1'b1;
                    state_d   = CAPTURE;
                end else begin
                    state_d = ARM;
                end
            end
            CAPTURE: begin
                if (word_done_s) begin
                    sample_data_d  = shift_q;
                    sample_valid_d = 1'b1;
                    sample_last_d  = (frame_cnt_q == LAST_IDX);
                    in_word_d      = 1'b0;
                    state_d        = HOLD;
                end else begin
                    state_d = CAPTURE;
                end
            end
            HOLD: begin
                if (word_done_s) begin
                    in_word_d = 1'b0;
                    overrun_d = 1'b1;
                    ovr_inc_s = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (handshake_s) begin
                    sample_valid_d = 1'b0;
                    sample_last_d  = 1'b0;
                    if (frame_cnt_q == LAST_IDX) begin
                        frame_cnt_d  = {FC_W{1'b0}};
                        frame_done_d = 1'b1;
                        in_word_d    = 1'b0;
                        state_d      = DONE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + {{(FC_W-1){1'b0}}, 1'b1};
                        in_word_d   = word_start_s;
                        state_d     = CAPTURE;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && state_q != IDLE) begin
            state_d        = IDLE;
            sample_valid_d = 1'b0;
            sample_last_d  = 1'b0;
            slot_d         = {SLOT_W{1'b0}};
            frame_cnt_d    = {FC_W{1'b0}};
            in_word_d      = 1'b0;
            frame_done_d   = 1'b0;
        end else begin
            frame_cnt_d = frame_cnt_d;
        end

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            bck_sync_q     <= 3'b000;
            lrck_sync_q    <= 3'b000;
            sd_sync_q      <= 3'b000;
            fall_pend_q    <= 1'b0;
            in_word_q      <= 1'b0;
            slot_q         <= {SLOT_W{1'b0}};
            shift_q        <= {SAMPLE_W{1'b0}};
            frame_cnt_q    <= {FC_W{1'b0}};
            sample_data_q  <= {SAMPLE_W{1'b0}};
            sample_valid_q <= 1'b0;
            sample_last_q  <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bck_sync_q     <= bck_sync_d;
            lrck_sync_q    <= lrck_sync_d;
            sd_sync_q      <= sd_sync_d;
            fall_pend_q    <= fall_pend_d;
            in_word_q      <= in_word_d;
            slot_q         <= slot_d;
            shift_q        <= shift_d;
            frame_cnt_q    <= frame_cnt_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            sample_last_q  <= sample_last_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
            overrun_q      <= overrun_d;
        end
    end

    assign smp.sample_data  = sample_data_q;
    assign smp.sample_valid = sample_valid_q;
    assign smp.sample_last  = sample_last_q;
    assign busy             = busy_q;
    assign frame_done       = frame_done_q;
    assign overrun          = overrun_q;

`ifdef I2S_CAP_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    // Saturating dropped-sample counter
    always_comb begin
        if (ovr_clr_s) begin
            ovr_cnt_d = 8'd0;
        end else if (ovr_inc_s && ovr_cnt_q != 8'hFF) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end else begin
            ovr_cnt_d = ovr_cnt_q;
        end
    end

    // Dropped-sample counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_cnt_q <= 8'd0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign overrun_cnt = ovr_cnt_q;
    logic ovr_unused_s;
    assign ovr_unused_s = sync_unused_s;
`else
    logic ovr_unused_s;
    assign ovr_unused_s = ovr_inc_s ^ ovr_clr_s ^ sync_unused_s;
    assign overrun_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_i2s_frame_capture.sv
// Directed bench for i2s_frame_capture: serializes I2S frames, scoreboards accepted samples.
`timescale 1ns/1ps
module tb_i2s_frame_capture;
    localparam int SW = 16;
    localparam int FL = 4;

    typedef struct {
        logic [SW-1:0] data;
        logic          last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, bck, lrck, sd, start, abort;
    logic       busy, frame_done, overrun;
    logic [7:0] overrun_cnt;

    i2s_frame_capture_if #(.SAMPLE_W(SW)) smp ();

    i2s_frame_capture #(.SAMPLE_W(SW), .FRAME_LEN(FL)) dut (
        .clk         (clk),
        .reset       (reset),
        .bck         (bck),
        .lrck        (lrck),
        .sd          (sd),
        .start       (start),
        .abort       (abort),
        .smp         (smp),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    always #10.417 clk = ~clk;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   accepted     = 0;
    int   done_pulses  = 0;
    bit   saw_right    = 1'b0;
    exp_t sb[$];
    logic [7:0] exp_ovr_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every accepted sample against the queued expectation
    always @(negedge clk) begin
        if (!reset && frame_done) done_pulses++;
        if (!reset && smp.sample_valid && smp.sample_ready) begin
            accepted++;
            if (smp.sample_data === 16'h1234) saw_right = 1'b1;
            if (sb.size() == 0) begin
                chk("unexpected_sample", 32'(smp.sample_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sample_data", 32'(smp.sample_data), 32'(e.data));
                chk("sample_last", 32'(smp.sample_last), 32'(e.last));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bck_cycle(input logic lr, input logic b);
        bck = 1'b0; lrck = lr; sd = b;
        repeat (8) @(negedge clk);
        bck = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_half(input logic lr, input logic [SW-1:0] w);
        bck_cycle(lr, 1'b0);
        for (int i = SW - 1; i >= 0; i--) bck_cycle(lr, w[i]);
        for (int i = 0; i < 32 - 1 - SW; i++) bck_cycle(lr, 1'b0);
    endtask

    task automatic send_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
        send_half(1'b0, l);
        send_half(1'b1, r);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; @(negedge clk); abort = 1'b0;
    endtask

    task automatic push(input logic [SW-1:0] d, input logic l);
        exp_t e;
        e.data = d; e.last = l;
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  32'(smp.sample_data),  32'd0);
        chk({tag, "_valid"}, 32'(smp.sample_valid), 32'd0);
        chk({tag, "_last"},  32'(smp.sample_last),  32'd0);
        chk({tag, "_busy"},  32'(busy),             32'd0);
        chk({tag, "_done"},  32'(frame_done),       32'd0);
        chk({tag, "_ovr"},   32'(overrun),          32'd0);
        chk({tag, "_ocnt"},  32'(overrun_cnt),      32'd0);
    endtask

    initial begin
        int dn0;
        int acc0;
        logic [SW-1:0] partial;
        partial = 16'hDEAD;
`ifdef I2S_CAP_OVERRUN_CNT_EN
        exp_ovr_cnt = 8'd1;
`else
        exp_ovr_cnt = 8'd0;
`endif
        reset = 1'b1; bck = 1'b0; lrck = 1'b1; sd = 1'b0;
        start = 1'b0; abort = 1'b0; smp.sample_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        bck_cycle(1'b1, 1'b0);
        bck_cycle(1'b1, 1'b0);

        // Basic frame with right-channel decoy words and a start pulse while busy
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        push(16'h8001, 1'b0); push(16'h7FFE, 1'b0); push(16'h0000, 1'b0); push(16'hFFFF, 1'b1);
        send_pair(16'h8001, 16'h1234);
        send_pair(16'h7FFE, 16'h1234);
        pulse_start();
        send_pair(16'h0000, 16'h1234);
        send_pair(16'hFFFF, 16'h1234);
        chk("frame1_accepted", 32'(accepted), 32'd4);
        chk("frame1_done_pulses", 32'(done_pulses), 32'd1);
        chk("frame1_idle", 32'(busy), 32'd0);
        chk("no_right_word", 32'(saw_right), 32'd0);
        chk("frame1_sb_empty", 32'(sb.size()), 32'd0);
        send_pair(16'h5555, 16'h1234);
        chk("idle_no_capture", 32'(accepted), 32'd4);

        // Overrun: ready low across two left words
        pulse_start();
        smp.sample_ready = 1'b0;
        push(16'h1111, 1'b0);
        send_pair(16'h1111, 16'h1234);
        chk("hold_valid", 32'(smp.sample_valid), 32'd1);
        chk("hold_data1", 32'(smp.sample_data), 32'h1111);
        chk("no_overrun_yet", 32'(overrun), 32'd0);
        send_pair(16'h2222, 16'h1234);
        chk("hold_data2", 32'(smp.sample_data), 32'h1111);
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("overrun_cnt", 32'(overrun_cnt), 32'(exp_ovr_cnt));
        smp.sample_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("overrun_accepted", 32'(accepted), 32'd5);
        pulse_abort();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("overrun_kept", 32'(overrun), 32'd1);
        pulse_start();
        chk("start_clr_ovr", 32'(overrun), 32'd0);
        chk("start_clr_ocnt", 32'(overrun_cnt), 32'd0);
        pulse_abort();

        // Abort after two samples, then a full frame
        dn0 = done_pulses;
        pulse_start();
        push(16'hA5A5, 1'b0); push(16'h5A5A, 1'b0);
        send_pair(16'hA5A5, 16'h1234);
        send_pair(16'h5A5A, 16'h1234);
        pulse_abort();
        chk("abort2_busy", 32'(busy), 32'd0);
        chk("abort2_valid", 32'(smp.sample_valid), 32'd0);
        acc0 = accepted;
        send_pair(16'h0F0F, 16'h1234);
        chk("abort2_no_done", 32'(done_pulses), 32'(dn0));
        chk("abort2_no_capture", 32'(accepted), 32'(acc0));
        pulse_start();
        push(16'h0001, 1'b0); push(16'h8000, 1'b0); push(16'h00FF, 1'b0); push(16'hFF00, 1'b1);
        send_pair(16'h0001, 16'h1234);
        send_pair(16'h8000, 16'h1234);
        send_pair(16'h00FF, 16'h1234);
        send_pair(16'hFF00, 16'h1234);
        chk("refill_done", 32'(done_pulses), 32'(dn0 + 1));
        chk("refill_accepted", 32'(accepted), 32'(acc0 + 4));
        chk("refill_idle", 32'(busy), 32'd0);

        // Reset in the middle of a left word
        dn0 = done_pulses;
        pulse_start();
        bck_cycle(1'b0, 1'b0);
        for (int i = SW - 1; i >= 8; i--) bck_cycle(1'b0, partial[i]);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("midreset");
        reset = 1'b0;
        pulse_start();
        for (int i = 7; i >= 0; i--) bck_cycle(1'b0, partial[i]);
        for (int i = 0; i < 32 - 1 - SW; i++) bck_cycle(1'b0, 1'b0);
        send_half(1'b1, 16'h1234);
        push(16'hBEEF, 1'b0);
        send_pair(16'hBEEF, 16'h1234);
        chk("midreset_no_done", 32'(done_pulses), 32'(dn0));
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        pulse_abort();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/i2s_frame_capture.md
I2S_FRAME_CAPTURE -- requirements
Module: i2s_frame_capture

Interface
REQ-001 Parameter SAMPLE_W, default 24: captured bits per left-channel sample, MSB first; legal range 8..32.
REQ-002 Parameter FRAME_LEN, default 256: samples per frame; power of two, range 4..1024.
REQ-003 Port clk  input  1  48 MHz master clock; the only clock in the block.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port bck  input  1  I2S bit clock from the BCK generator; asynchronous to clk sampling.
REQ-006 Port lrck  input  1  I2S word clock; low means left channel.
REQ-007 Port sd  input  1  I2S serial data from the microphone.
REQ-008 Port start  input  1  single-cycle pulse that arms the capture of one frame.
REQ-009 Port abort  input  1  single-cycle pulse that cancels the frame in progress.
REQ-010 Port sample_data  output  SAMPLE_W  captured sample as two's complement.
REQ-011 Port sample_valid  output  1  sample_data is valid.
REQ-012 Port sample_ready  input  1  downstream (FFT input buffer) accepts the sample.
REQ-013 Port sample_last  output  1  high together with sample_valid on sample FRAME_LEN-1.
REQ-014 Port busy  output  1  high in every state except IDLE.
REQ-015 Port frame_done  output  1  one-cycle pulse after the last sample is accepted.
REQ-016 Port overrun  output  1  sticky flag; set when a sample is dropped.
REQ-017 Port overrun_cnt  output  8  count of dropped samples (see Configuration).

Function
REQ-018 bck, lrck and sd shall each pass through a 2-flop synchronizer followed by a 3rd stage used for edge detection; all three shall share identical latency.
REQ-019 A bck rise shall be detected when stage3=0 and stage2=1; an lrck fall shall be detected when lrck stage3=1 and stage2=0.
REQ-020 FSM states: IDLE, ARM, CAPTURE, HOLD, DONE.
REQ-021 IDLE: on start, go to ARM; start is ignored in every other state.
REQ-022 ARM: on a detected lrck fall coincident with a bck rise, clear the slot counter and go to CAPTURE; that bck edge is the I2S delay slot and captures no bit.
REQ-023 CAPTURE: on each bck rise while synchronized lrck is low, increment the slot; on edges k=1..SAMPLE_W, shift synchronized sd into the shift register LSB (MSB arrives first).
REQ-024 After edge SAMPLE_W, the next clk cycle shall load sample_data, assert sample_valid, and enter HOLD.
REQ-025 HOLD: sample_data and sample_valid shall remain stable until a cycle with sample_valid && sample_ready; on that handshake, increment the frame counter and deassert sample_valid.
REQ-026 After the handshake, go to DONE if the accepted sample was FRAME_LEN-1; otherwise return to CAPTURE and wait for the next lrck fall.
REQ-027 If the next left word completes while still in HOLD, drop the new word, keep the held sample, set overrun, and increment overrun_cnt.
REQ-028 DONE: assert frame_done for exactly one cycle, then go to IDLE; the frame counter wraps to 0.
REQ-029 abort in any non-IDLE state shall force IDLE on the next cycle and clear sample_valid, the slot counter and the frame counter; overrun shall be kept.
REQ-030 If abort and a handshake occur in the same cycle, abort wins and the sample counts as consumed.
REQ-031 start while in IDLE shall clear overrun and overrun_cnt.
REQ-032 Right-channel bits (lrck high) shall never be captured.

Reset
REQ-033 On reset, the FSM shall enter IDLE and all outputs shall be 0: sample_data, sample_valid, sample_last, busy, frame_done, overrun and overrun_cnt.
REQ-034 On reset, the synchronizers, the shift register and all counters shall clear to 0; reset mid-frame discards the partial frame without asserting frame_done.

Configuration
REQ-035 With I2S_CAP_OVERRUN_CNT_EN defined, overrun_cnt shall count dropped samples and saturate at 255.
REQ-036 Without I2S_CAP_OVERRUN_CNT_EN, overrun_cnt shall be tied to 0 and no counter logic shall be synthesized; overrun itself shall be unaffected.

Verification
REQ-037 Setup SAMPLE_W=16, FRAME_LEN=4, bck=3 MHz, lrck=bck/64, ready held high; left words 0x8001, 0x7FFE, 0x0000, 0xFFFF -> four valid handshakes with those exact values, sample_last only on 0xFFFF, one frame_done pulse.
REQ-038 Same stimulus with right-channel words set to 0x1234 -> no output sample equals 0x1234.
REQ-039 Hold ready low across two left words -> the first word is held stable, overrun=1, overrun_cnt=1 with the macro defined, 0 without it.
REQ-040 Pulse abort after sample 2 -> IDLE next cycle, busy=0, no frame_done; a new start then yields a full 4-sample frame.
REQ-041 Assert reset mid-word, then start -> all outputs 0 during reset; the first captured word is the next complete left word, not a partial one.
REQ-042 Pulse start while busy -> no effect; frame length remains 4.
